// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, FSM states, ALU classes
// and datapath mux-select codes.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FUNCT_JR = 6'h08;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_REX    = 4'd7,
        S_RWB    = 4'd8,
        S_IEX    = 4'd9,
        S_IWB    = 4'd10,
        S_BRANCH = 4'd11,
        S_JUMP   = 4'd12,
        S_JAL    = 4'd13,
        S_JR     = 4'd14
    } state_e;

    localparam logic [2:0] ALUOP_RTYPE = 3'b111;
    localparam logic [2:0] ALUOP_ADD   = 3'b011;
    localparam logic [2:0] ALUOP_SUB   = 3'b010;
    localparam logic [2:0] ALUOP_OR    = 3'b001;
    localparam logic [2:0] ALUOP_AND   = 3'b110;
    localparam logic [2:0] ALUOP_LUI   = 3'b101;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;
    localparam logic [1:0] PCSRC_REGA   = 2'd3;

    localparam logic [1:0] ALUB_REGB    = 2'd0;
    localparam logic [1:0] ALUB_FOUR    = 2'd1;
    localparam logic [1:0] ALUB_IMM     = 2'd2;
    localparam logic [1:0] ALUB_IMM_SH2 = 2'd3;

    localparam logic [1:0] REGDST_RT = 2'd0;
    localparam logic [1:0] REGDST_RD = 2'd1;
    localparam logic [1:0] REGDST_RA = 2'd2;

    localparam logic [1:0] MEM2REG_ALUOUT = 2'd0;
    localparam logic [1:0] MEM2REG_MDR    = 2'd1;
    localparam logic [1:0] MEM2REG_PC     = 2'd2;

    // ALU class for the immediate-arithmetic execute step.
    function automatic logic [2:0] imm_aluop(input logic [5:0] op);
        case (op)
            OP_ORI:  return ALUOP_OR;
            OP_ANDI: return ALUOP_AND;
            OP_LUI:  return ALUOP_LUI;
            default: return ALUOP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control.sv
// Multicycle MIPS control unit: Moore FSM driving datapath selects, write strobes and a
// req/ready memory handshake, with a retired-instruction counter and sticky illegal flag.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IorD,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             PCWriteCondEQ,
    output logic             PCWriteCondNE,
    output logic [1:0]       PCSrc,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ALUOp,
    output logic [1:0]       RegDst,
    output logic [1:0]       MemtoReg,
    output logic             RegWrite,
    output logic [3:0]       state_o,
    output logic [CNT_W-1:0] instr_retired,
    output logic             illegal_op
);

    state_e           r_state;
    state_e           w_state_next;
    logic [5:0]       r_op;
    logic [CNT_W-1:0] r_retired;
    logic             r_illegal;
    logic             w_retire;
    logic             w_illegal_set;

    // Opcode is latched in DECODE so later states never look at a changing IR.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_op      <= '0;
            r_retired <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_DECODE) begin
                r_op <= opcode;
            end
            if (w_retire) begin
                r_retired <= r_retired + CNT_W'(1);
            end
            if (w_illegal_set) begin
                r_illegal <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_retire      = 1'b0;
        w_illegal_set = 1'b0;
        mem_req       = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        IorD          = 1'b0;
        IRWrite       = 1'b0;
        PCWrite       = 1'b0;
        PCWriteCondEQ = 1'b0;
        PCWriteCondNE = 1'b0;
        PCSrc         = PCSRC_ALU;
        ALUSrcA       = 1'b0;
        ALUSrcB       = ALUB_REGB;
        ALUOp         = 3'b000;
        RegDst        = REGDST_RT;
        MemtoReg      = MEM2REG_ALUOUT;
        RegWrite      = 1'b0;

        unique case (r_state)
            S_IDLE: w_state_next = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                MemRead = 1'b1;
                ALUSrcB = ALUB_FOUR;
                ALUOp   = ALUOP_ADD;
                if (mem_ready) begin
                    IRWrite      = 1'b1;
                    PCWrite      = 1'b1;
                    w_state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcB = ALUB_IMM_SH2;
                ALUOp   = ALUOP_ADD;
                case (opcode)
                    OP_LW, OP_SW: w_state_next = S_MEMADR;
                    OP_RTYPE:     w_state_next = (funct == FUNCT_JR) ? S_JR : S_REX;
                    OP_ADDI, OP_ORI, OP_ANDI, OP_LUI: w_state_next = S_IEX;
                    OP_BEQ, OP_BNE: w_state_next = S_BRANCH;
                    OP_J:         w_state_next = S_JUMP;
                    OP_JAL:       w_state_next = S_JAL;
                    default: begin
                        w_state_next  = S_FETCH;
                        w_illegal_set = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA      = 1'b1;
                ALUSrcB      = ALUB_IMM;
                ALUOp        = ALUOP_ADD;
                w_state_next = (r_op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) begin
                    w_state_next = S_MEMWB;
                end
            end
            S_MEMWB: begin
                RegWrite     = 1'b1;
                RegDst       = REGDST_RT;
                MemtoReg     = MEM2REG_MDR;
                w_state_next = S_FETCH;
                w_retire     = 1'b1;
            end
            S_MEMWR: begin
                mem_req  = 1'b1;
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_ready) begin
                    w_state_next = S_FETCH;
                    w_retire     = 1'b1;
                end
            end
            S_REX: begin
                ALUSrcA      = 1'b1;
                ALUSrcB      = ALUB_REGB;
                ALUOp        = ALUOP_RTYPE;
                w_state_next = S_RWB;
            end
            S_RWB: begin
                RegWrite     = 1'b1;
                RegDst       = REGDST_RD;
                MemtoReg     = MEM2REG_ALUOUT;
                w_state_next = S_FETCH;
                w_retire     = 1'b1;
            end
            S_IEX: begin
                ALUSrcA      = 1'b1;
                ALUSrcB      = ALUB_IMM;
                ALUOp        = imm_aluop(r_op);
                w_state_next = S_IWB;
            end
            S_IWB: begin
                RegWrite     = 1'b1;
                RegDst       = REGDST_RT;
                MemtoReg     = MEM2REG_ALUOUT;
                w_state_next = S_FETCH;
                w_retire     = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA       = 1'b1;
                ALUSrcB       = ALUB_REGB;
                ALUOp         = ALUOP_SUB;
                PCSrc         = PCSRC_ALUOUT;
                PCWriteCondEQ = (r_op == OP_BEQ);
                PCWriteCondNE = (r_op == OP_BNE);
                w_state_next  = S_FETCH;
                w_retire      = 1'b1;
            end
            S_JUMP: begin
                PCWrite      = 1'b1;
                PCSrc        = PCSRC_JUMP;
                w_state_next = S_FETCH;
                w_retire     = 1'b1;
            end
            S_JAL: begin
                PCWrite      = 1'b1;
                PCSrc        = PCSRC_JUMP;
                RegWrite     = 1'b1;
                RegDst       = REGDST_RA;
                MemtoReg     = MEM2REG_PC;
                w_state_next = S_FETCH;
                w_retire     = 1'b1;
            end
            S_JR: begin
                PCWrite      = 1'b1;
                PCSrc        = PCSRC_REGA;
                w_state_next = S_FETCH;
                w_retire     = 1'b1;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign state_o       = r_state;
    assign instr_retired = r_retired;
    assign illegal_op    = r_illegal;

endmodule
